// File: rtl/pll_seq_pkg.sv
// Shared types for the video PLL reset/lock supervisor: state encoding and
// loss-counter width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } pll_seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Sizes the shared phase counter from the longest of the three intervals.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into the refclk domain.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Video PLL reset and lock supervisor: holds the PLL in reset, qualifies lock,
// releases sys_rst_n, retries on failure and latches FAULT until restart.
// Optional lock-loss counter enabled by defining PLL_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  restart,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  fault,
  output logic                  lock_lost,
  output logic [2:0]            state_o,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RET_W   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_LIMIT   = RET_W'(MAX_RETRIES);

  pll_seq_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RET_W-1:0] r_retries;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_fault;
  logic             r_lock_lost;

  pll_seq_state_t   w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [RET_W-1:0] w_ret_nx;
  logic [RET_W-1:0] w_ret_inc;
  logic             w_fail;
  logic             w_loss_evt;
  logic             w_lock_s;

  pll_lock_sync u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (locked),
    .o_q     (w_lock_s)
  );

  assign w_ret_inc = r_retries + RET_W'(1);

  // Next-state decode; restart outranks every state-local decision.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_ret_nx   = r_retries;
    w_fail     = 1'b0;
    w_loss_evt = 1'b0;
    if (restart) begin
      w_state_nx = ST_RESET_HOLD;
      w_cnt_nx   = '0;
      w_ret_nx   = '0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_cnt == RST_LAST) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nx = ST_STABLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == LOCK_LAST) begin
            w_fail = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_fail = 1'b1;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
            w_ret_nx   = '0;
          end
        end
        ST_RUN: begin
          w_cnt_nx = '0;
          if (!w_lock_s) begin
            w_state_nx = ST_RESET_HOLD;
            w_loss_evt = 1'b1;
          end
        end
        ST_FAULT: begin
          w_cnt_nx = '0;
        end
        default: begin
          w_state_nx = ST_RESET_HOLD;
          w_cnt_nx   = '0;
        end
      endcase
      // A lock loss in RUN is not an attempt failure and leaves retries alone.
      if (w_fail) begin
        w_ret_nx = w_ret_inc;
        w_cnt_nx = '0;
        w_state_nx = (w_ret_inc == RET_LIMIT) ? ST_FAULT : ST_RESET_HOLD;
      end
    end
  end

  // Outputs decode the next state so they line up exactly with r_state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET_HOLD;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_retries   <= w_ret_nx;
      r_pll_rst   <= (w_state_nx == ST_RESET_HOLD) || (w_state_nx == ST_FAULT);
      r_sys_rst_n <= (w_state_nx == ST_RUN);
      r_fault     <= (w_state_nx == ST_FAULT);
      r_lock_lost <= w_loss_evt;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign fault     = r_fault;
  assign lock_lost = r_lock_lost;
  assign state_o   = r_state;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
      r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign loss_count = r_loss_cnt;
`else
  assign loss_count = '0;
`endif

endmodule
